// File: rtl/vx_tex_sat_arb.sv
// vx_tex_sat_arb: round-robin arbiter feeding a shared per-lane unsigned saturation stage with a registered response.
// Optional perf counters are enabled by defining TEX_SAT_ARB_PERF_EN.
module vx_tex_sat_arb #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_LANES = 4,
  parameter int IN_W      = 12,
  parameter int OUT_W     = 8,
  parameter int TAG_W     = 8,
  localparam int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS*NUM_LANES*IN_W-1:0] req_data,
  input  logic [NUM_REQS*TAG_W-1:0]      req_tag,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           rsp_valid,
  output logic [NUM_LANES*OUT_W-1:0]     rsp_data,
  output logic [IDX_W-1:0]               rsp_idx,
  output logic [TAG_W-1:0]               rsp_tag,
  input  logic                           rsp_ready,
  output logic [31:0]                    perf_underflows,
  output logic [31:0]                    perf_overflows
);
  if (OUT_W + 1 >= IN_W) begin : g_width_check
    $error("vx_tex_sat_arb: OUT_W+1 must be less than IN_W");
  end
  logic                       rsp_valid_q;
  logic [NUM_LANES*OUT_W-1:0] rsp_data_q, rsp_data_d;
  logic [IDX_W-1:0]           rsp_idx_q, rr_q, gidx;
  logic [TAG_W-1:0]           rsp_tag_q;
  logic [NUM_LANES-1:0]       unf, ovf;
  logic                       fire;
  int                         idx;
  assign fire = |req_valid && (!rsp_valid_q || rsp_ready) && !reset;
  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gidx = '0;
    idx  = 0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQS;
      if (req_valid[idx]) gidx = IDX_W'(idx);
    end
    req_ready = fire ? NUM_REQS'(1) << gidx : '0;
  end
  always_comb begin
    unf        = '0;
    ovf        = '0;
    rsp_data_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      unf[l] = req_data[(int'(gidx) * NUM_LANES + l) * IN_W + IN_W - 1];
      ovf[l] = !unf[l] && |req_data[(int'(gidx) * NUM_LANES + l) * IN_W + OUT_W +: IN_W - OUT_W - 1];
      rsp_data_d[l*OUT_W +: OUT_W] = unf[l] ? '0 : ovf[l] ? '1 :
                                     req_data[(int'(gidx) * NUM_LANES + l) * IN_W +: OUT_W];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_idx_q   <= '0;
      rsp_tag_q   <= '0;
      rr_q        <= '0;
    end else if (fire) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rsp_data_d;
      rsp_idx_q   <= gidx;
      rsp_tag_q   <= req_tag[int'(gidx) * TAG_W +: TAG_W];
      rr_q        <= (gidx == IDX_W'(NUM_REQS - 1)) ? '0 : gidx + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_tag   = rsp_tag_q;
`ifdef TEX_SAT_ARB_PERF_EN
  logic [31:0] unf_q, ovf_q, unf_n, ovf_n;
  always_comb begin
    unf_n = '0;
    ovf_n = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      unf_n = unf_n + 32'(unf[l]);
      ovf_n = ovf_n + 32'(ovf[l]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      unf_q <= '0;
      ovf_q <= '0;
    end else if (fire) begin
      unf_q <= unf_q + unf_n;
      ovf_q <= ovf_q + ovf_n;
    end
  end
  assign perf_underflows = unf_q;
  assign perf_overflows  = ovf_q;
`else
  assign perf_underflows = '0;
  assign perf_overflows  = '0;
`endif
endmodule

// File: tb/tb_vx_tex_sat_arb.sv
// tb_vx_tex_sat_arb: directed checks of clamping, round-robin fairness, backpressure and reset for vx_tex_sat_arb.
module tb_vx_tex_sat_arb;
  localparam int NR = 4, NL = 4, IW = 12, OW = 8, TW = 8;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*NL*IW-1:0] req_data = '0;
  logic [NR*TW-1:0] req_tag = '0;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic [NL*OW-1:0] rsp_data;
  logic [1:0]      rsp_idx;
  logic [TW-1:0]   rsp_tag;
  logic            rsp_ready = 1'b1;
  logic [31:0]     perf_underflows, perf_overflows;
  int vecs = 0, errs = 0;
`ifdef TEX_SAT_ARB_PERF_EN
  localparam logic [31:0] EXP_UNF = 32'd1, EXP_OVF = 32'd1;
`else
  localparam logic [31:0] EXP_UNF = 32'd0, EXP_OVF = 32'd0;
`endif
  vx_tex_sat_arb #(.NUM_REQS(NR), .NUM_LANES(NL), .IN_W(IW), .OUT_W(OW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_idx(rsp_idx),
    .rsp_tag(rsp_tag), .rsp_ready(rsp_ready), .perf_underflows(perf_underflows),
    .perf_overflows(perf_overflows));
  always #5 clk = ~clk;
  function automatic logic [NL*OW-1:0] small_exp(input int r);
    logic [NL*OW-1:0] v;
    for (int l = 0; l < NL; l++) v[l*OW +: OW] = 8'(r * 16 + l);
    return v;
  endfunction
  task automatic load_defaults();
    for (int r = 0; r < NR; r++) begin
      req_tag[r*TW +: TW] = 8'hA0 + 8'(r);
      for (int l = 0; l < NL; l++) req_data[(r*NL+l)*IW +: IW] = 12'(r * 16 + l);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    req_valid = '1;
    #1;
    vecs++;
    if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    tick();
    vecs++;
    if ({rsp_valid, rsp_data, rsp_idx, rsp_tag} !== '0) begin
      errs++; $display("FAIL reset_rsp got v=%b d=%h i=%0d t=%h exp all 0", rsp_valid, rsp_data, rsp_idx, rsp_tag);
    end
    vecs++;
    if (perf_underflows !== 32'd0 || perf_overflows !== 32'd0) begin
      errs++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_underflows, perf_overflows);
    end
    req_valid = '0;
    reset = 1'b0;
  endtask
  task automatic test_clamp();
    req_data[0*IW +: IW] = 12'hFFF;
    req_data[1*IW +: IW] = 12'h100;
    req_data[2*IW +: IW] = 12'h0FF;
    req_data[3*IW +: IW] = 12'h07A;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    vecs++;
    if (req_ready !== 4'b0001) begin errs++; $display("FAIL clamp_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h7AFFFF00 || rsp_idx !== 2'd0 || rsp_tag !== 8'hA0) begin
      errs++; $display("FAIL clamp_rsp got v=%b d=%h i=%0d t=%h exp 1 7affff00 0 a0", rsp_valid, rsp_data, rsp_idx, rsp_tag);
    end
    vecs++;
    if (perf_underflows !== EXP_UNF || perf_overflows !== EXP_OVF) begin
      errs++; $display("FAIL clamp_perf got %0d/%0d exp %0d/%0d", perf_underflows, perf_overflows, EXP_UNF, EXP_OVF);
    end
    tick();
    vecs++;
    if (rsp_valid !== 1'b0) begin errs++; $display("FAIL clamp_drain got %b exp 0", rsp_valid); end
    load_defaults();
  endtask
  task automatic test_round_robin();
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      vecs++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        errs++; $display("FAIL rr_ready[%0d] got %b exp %b", c, req_ready, 4'(1 << (c % 4)));
      end
      tick();
      vecs++;
      if (rsp_valid !== 1'b1 || rsp_idx !== 2'(c % 4) || rsp_tag !== 8'hA0 + 8'(c % 4) || rsp_data !== small_exp(c % 4)) begin
        errs++; $display("FAIL rr_rsp[%0d] got v=%b i=%0d t=%h d=%h exp 1 %0d %h %h", c, rsp_valid, rsp_idx, rsp_tag, rsp_data, c % 4, 8'hA0 + 8'(c % 4), small_exp(c % 4));
      end
    end
    req_valid = '0;
  endtask
  task automatic test_back_to_back();
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++;
      if (req_ready !== 4'b0000) begin errs++; $display("FAIL bp_ready[%0d] got %b exp 0000", c, req_ready); end
      tick();
      vecs++;
      if (rsp_valid !== 1'b1 || rsp_idx !== 2'd2 || rsp_tag !== 8'hA2 || rsp_data !== small_exp(2)) begin
        errs++; $display("FAIL bp_hold[%0d] got v=%b i=%0d t=%h d=%h exp 1 2 a2 %h", c, rsp_valid, rsp_idx, rsp_tag, rsp_data, small_exp(2));
      end
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    vecs++;
    if (req_ready !== 4'b0010) begin errs++; $display("FAIL bp_release_ready got %b exp 0010", req_ready); end
    tick();
    req_valid = '0;
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_idx !== 2'd1 || rsp_tag !== 8'hA1) begin
      errs++; $display("FAIL bp_release_rsp got v=%b i=%0d t=%h exp 1 1 a1", rsp_valid, rsp_idx, rsp_tag);
    end
  endtask
  task automatic test_sparse();
    do_reset();
    req_valid = 4'b1000;
    #1;
    vecs++;
    if (req_ready !== 4'b1000) begin errs++; $display("FAIL sparse_ready got %b exp 1000", req_ready); end
    tick();
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_idx !== 2'd3 || rsp_tag !== 8'hA3) begin
      errs++; $display("FAIL sparse_rsp got v=%b i=%0d t=%h exp 1 3 a3", rsp_valid, rsp_idx, rsp_tag);
    end
    req_valid = '1;
    #1;
    vecs++;
    if (req_ready !== 4'b0001) begin errs++; $display("FAIL sparse_wrap_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    vecs++;
    if (rsp_idx !== 2'd0 || rsp_tag !== 8'hA0) begin
      errs++; $display("FAIL sparse_wrap_rsp got i=%0d t=%h exp 0 a0", rsp_idx, rsp_tag);
    end
  endtask
  task automatic test_reset_mid();
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    tick();
    req_valid = '1;
    rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    vecs++;
    if (req_ready !== 4'b0000) begin errs++; $display("FAIL mid_reset_ready got %b exp 0000", req_ready); end
    tick();
    reset = 1'b0;
    vecs++;
    if (rsp_valid !== 1'b0 || perf_underflows !== 32'd0 || perf_overflows !== 32'd0) begin
      errs++; $display("FAIL mid_reset_rsp got v=%b u=%0d o=%0d exp 0 0 0", rsp_valid, perf_underflows, perf_overflows);
    end
    rsp_ready = 1'b1;
    #1;
    vecs++;
    if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_reset_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_idx !== 2'd0) begin
      errs++; $display("FAIL mid_reset_first got v=%b i=%0d exp 1 0", rsp_valid, rsp_idx);
    end
  endtask
  initial begin
    load_defaults();
    test_reset();
    test_clamp();
    test_round_robin();
    test_back_to_back();
    test_sparse();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
